// File: rtl/vedic_16x16.sv
// Unsigned 16x16 -> 32-bit multiplier built from Urdhva-Tiryagbhyam blocks
// (2x2 -> 4x4 -> 8x8 -> 16x16), with the product registered once.

module vedic_2x2 (
  input  logic [1:0] i_a,
  input  logic [1:0] i_b,
  output logic [3:0] o_p
);
  logic [1:0] w_cross;
  logic       w_hi;

  // Crosswise column: the two 1-bit products summed, carry moves up one column
  assign w_cross = {1'b0, i_a[1] & i_b[0]} + {1'b0, i_a[0] & i_b[1]};
  assign w_hi    = i_a[1] & i_b[1];
  assign o_p     = {w_hi & w_cross[1], w_hi ^ w_cross[1], w_cross[0], i_a[0] & i_b[0]};
endmodule

module vedic_combine #(
  parameter int N = 4
) (
  input  logic [N-1:0]   i_ll,
  input  logic [N-1:0]   i_hl,
  input  logic [N-1:0]   i_lh,
  input  logic [N-1:0]   i_hh,
  output logic [2*N-1:0] o_p
);
  localparam int H = N / 2;

  logic [N:0]     w_cross;
  logic [N+H-1:0] w_upper;

  // N+1-bit cross sum keeps its carry; the upper sum cannot exceed N+H bits
  assign w_cross = {1'b0, i_hl} + {1'b0, i_lh};
  assign w_upper = {i_hh, i_ll[N-1:H]} + {{(H-1){1'b0}}, w_cross};
  assign o_p     = {w_upper, i_ll[H-1:0]};
endmodule

module vedic_4x4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [7:0] o_p
);
  logic [3:0] w_ll, w_hl, w_lh, w_hh;

  vedic_2x2 u_ll (.i_a(i_a[1:0]), .i_b(i_b[1:0]), .o_p(w_ll));
  vedic_2x2 u_hl (.i_a(i_a[3:2]), .i_b(i_b[1:0]), .o_p(w_hl));
  vedic_2x2 u_lh (.i_a(i_a[1:0]), .i_b(i_b[3:2]), .o_p(w_lh));
  vedic_2x2 u_hh (.i_a(i_a[3:2]), .i_b(i_b[3:2]), .o_p(w_hh));

  vedic_combine #(.N(4)) u_comb (
    .i_ll(w_ll), .i_hl(w_hl), .i_lh(w_lh), .i_hh(w_hh), .o_p(o_p)
  );
endmodule

module vedic_8x8 (
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_b,
  output logic [15:0] o_p
);
  logic [7:0] w_ll, w_hl, w_lh, w_hh;

  vedic_4x4 u_ll (.i_a(i_a[3:0]), .i_b(i_b[3:0]), .o_p(w_ll));
  vedic_4x4 u_hl (.i_a(i_a[7:4]), .i_b(i_b[3:0]), .o_p(w_hl));
  vedic_4x4 u_lh (.i_a(i_a[3:0]), .i_b(i_b[7:4]), .o_p(w_lh));
  vedic_4x4 u_hh (.i_a(i_a[7:4]), .i_b(i_b[7:4]), .o_p(w_hh));

  vedic_combine #(.N(8)) u_comb (
    .i_ll(w_ll), .i_hl(w_hl), .i_lh(w_lh), .i_hh(w_hh), .o_p(o_p)
  );
endmodule

module vedic_16x16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] out,
  output logic        out_valid
);
  logic [15:0] w_ll, w_hl, w_lh, w_hh;
  logic [31:0] w_prod;
  logic [31:0] r_out;
  logic        r_out_valid;

  vedic_8x8 u_ll (.i_a(a[7:0]),  .i_b(b[7:0]),  .o_p(w_ll));
  vedic_8x8 u_hl (.i_a(a[15:8]), .i_b(b[7:0]),  .o_p(w_hl));
  vedic_8x8 u_lh (.i_a(a[7:0]),  .i_b(b[15:8]), .o_p(w_lh));
  vedic_8x8 u_hh (.i_a(a[15:8]), .i_b(b[15:8]), .o_p(w_hh));

  vedic_combine #(.N(16)) u_comb (
    .i_ll(w_ll), .i_hl(w_hl), .i_lh(w_lh), .i_hh(w_hh), .o_p(w_prod)
  );

  // Output register: product every cycle, valid follows in_valid, reset wins
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out       <= 32'h0000_0000;
      r_out_valid <= 1'b0;
    end else begin
      r_out       <= w_prod;
      r_out_valid <= in_valid;
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
endmodule

// File: tb/tb_vedic_16x16.sv
// Self-checking bench for vedic_16x16: arithmetic reference model checked every
// cycle plus directed vectors with hand-computed expected products.

module tb_vedic_16x16;
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic [31:0] out;
  logic        out_valid;

  int n_tests = 0;
  int n_fail  = 0;

  vedic_16x16 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .a(a), .b(b), .out(out), .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: 1-cycle-late plain product, reset clears
  always @(posedge clk) begin
    logic [63:0] m_prod;
    logic [31:0] m_out;
    logic        m_valid;
    m_prod = 64'(a) * 64'(b);
    if (rst) begin
      m_out   = 32'h0;
      m_valid = 1'b0;
    end else begin
      m_out   = m_prod[31:0];
      m_valid = in_valid;
    end
    #1;
    check("model_out", out, m_out);
    check("model_valid", {31'b0, out_valid}, {31'b0, m_valid});
  end

  task automatic drive(input logic r, input logic v, input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    rst = r; in_valid = v; a = x; b = y;
  endtask

  task automatic lit(input string name, input logic [31:0] eo, input logic ev);
    @(posedge clk);
    #1;
    check(name, out, eo);
    check({name, "_valid"}, {31'b0, out_valid}, {31'b0, ev});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
    lit("reset_0", 32'h0000_0000, 1'b0);
    lit("reset_1", 32'h0000_0000, 1'b0);
    drive(1'b0, 1'b1, 16'hFFFF, 16'hFFFF); lit("after_reset_max", 32'hFFFE_0001, 1'b1);

    drive(1'b0, 1'b1, 16'h0000, 16'hFFFF); lit("zero_x_max", 32'h0000_0000, 1'b1);
    drive(1'b0, 1'b1, 16'h0001, 16'hFFFF); lit("one_x_max",  32'h0000_FFFF, 1'b1);
    drive(1'b0, 1'b1, 16'hFFFF, 16'hFFFF); lit("max_x_max",  32'hFFFE_0001, 1'b1);
    drive(1'b0, 1'b1, 16'h8000, 16'h0002); lit("msb_x_two",  32'h0001_0000, 1'b1);

    drive(1'b0, 1'b1, 16'h1234, 16'h5678); lit("cross_1234_5678", 32'h0626_0060, 1'b1);
    drive(1'b0, 1'b1, 16'h00FF, 16'h0100); lit("cross_00ff_0100", 32'h0000_FF00, 1'b1);
    drive(1'b0, 1'b1, 16'hFF00, 16'h00FF); lit("cross_ff00_00ff", 32'h00FE_0100, 1'b1);

    drive(1'b0, 1'b1, 16'd3, 16'd5); lit("gate_3x5", 32'd15, 1'b1);
    drive(1'b0, 1'b0, 16'd7, 16'd9); lit("gate_7x9", 32'd63, 1'b0);
    drive(1'b0, 1'b1, 16'd2, 16'd2); lit("gate_2x2", 32'd4,  1'b1);

    // Streaming: model checks every edge; one-cycle reset dropped in mid-way
    for (int i = 0; i < 200; i++) begin
      if (i == 100) begin
        drive(1'b1, 1'b1, 16'hABCD, 16'h1234); lit("mid_reset", 32'h0000_0000, 1'b0);
        drive(1'b0, 1'b1, 16'd3, 16'd4);       lit("resume",    32'd12,        1'b1);
      end else begin
        drive(1'b0, 1'b1, 16'($urandom), 16'($urandom));
      end
    end

    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
